bcd_scan_display: RTL and testbench

//   Multiplexed 7-segment display driver that consumes the BCD digits of the

---
 rtl/bcd_scan_display.sv | 88 ++++++++
 tb/tb_bcd_scan_display.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment driver: scans DIGITS BCD nibbles onto one segment bus
// with a one-hot anode select. Define LZB_EN to enable leading-zero blanking.
module bcd_scan_display #(
  parameter  int DIGITS   = 4,
  parameter  int PRESCALE = 4,
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [IW-1:0]         digit_idx
);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000; // invalid nibble shows a dash
    endcase
  endfunction

  assign nibble = bcd[4*idx +: 4];

`ifdef LZB_EN
  logic all_zero;

  // Walk from the top digit down; a digit is blanked while every digit at or
  // above it is zero. Digit 0 is never visited, so it always displays.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    all_zero = 1'b1;
    blank    = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero && (bcd[4*i +: 4] == 4'd0);
      if (IW'(i) == idx) blank = all_zero;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? 7'd0 : decode(nibble);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge idx, which is what the outputs must reflect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      idx       <= '0;
      seg       <= '0;
      an        <= '0;
      digit_idx <= '0;
    end else if (en) begin
      an        <= DIGITS'(1) << idx;
      digit_idx <= idx;
      seg       <= seg_next;
      if (presc == PW'(PRESCALE - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end else begin
      // Disabled: blank the display; scan position and digit_idx hold.
      seg <= '0;
      an  <= '0;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (DIGITS=4, PRESCALE=4): vector
// table, hand sequences for corner cases, and randomized model comparison.
module tb_bcd_scan_display;

  localparam int D = 4;
  localparam int P = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en;
  logic [15:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int checks   = 0;
  int failures = 0;

  bcd_scan_display #(.DIGITS(D), .PRESCALE(P)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .bcd       (bcd),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S4 = 7'b1100110, S7 = 7'b0000111,
                         S9 = 7'b1101111, DASH = 7'b1000000;

  logic [6:0] seg_tab [0:15];

  // Reference model: position is derived from the count of enabled edges.
  int         m_count;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic [1:0] m_idx;

  function automatic logic [6:0] ref_seg(input logic [15:0] b, input int d);
    logic [15:0] upper;
    upper = b >> (4 * d);
`ifdef LZB_EN
    if (d > 0 && upper == 16'd0) return 7'd0;
`endif
    return seg_tab[upper[3:0]];
  endfunction

  task automatic model_reset();
    m_count = 0; m_seg = '0; m_an = '0; m_idx = '0;
  endtask

  task automatic model_edge(input logic e, input logic [15:0] b);
    int d;
    if (e) begin
      d       = (m_count / P) % D;
      m_an    = 4'(1 << d);
      m_idx   = 2'(d);
      m_seg   = ref_seg(b, d);
      m_count = m_count + 1;
    end else begin
      m_an  = '0;
      m_seg = '0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic [1:0] e_idx);
    check({name, ".an"},  32'(an),        32'(e_an));
    check({name, ".seg"}, 32'(seg),       32'(e_seg));
    check({name, ".idx"}, 32'(digit_idx), 32'(e_idx));
  endtask

  // Called at a negedge; applies inputs, takes one rising edge, returns at next negedge.
  task automatic step(input logic e, input logic [15:0] b);
    en  = e;
    bcd = b;
    model_edge(e, b);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic steps(input int n, input logic e, input logic [15:0] b);
    for (int k = 0; k < n; k++) step(e, b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic e, input logic [15:0] b,
                     input logic [3:0] a, input logic [6:0] s, input logic [1:0] i);
    vec_t v;
    v.en = e; v.bcd = b; v.an = a; v.seg = s; v.idx = i;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    seg_tab = '{S0, S1, S2, S3, S4, 7'b1101101, 7'b1111101, S7, 7'b1111111, S9,
                DASH, DASH, DASH, DASH, DASH, DASH};

    // Full scan with wrap, then a freeze in the 2nd cycle of digit 1.
    add(4, 1'b1, 16'h1234, 4'b0001, S4, 2'd0);
    add(4, 1'b1, 16'h1234, 4'b0010, S3, 2'd1);
    add(4, 1'b1, 16'h1234, 4'b0100, S2, 2'd2);
    add(4, 1'b1, 16'h1234, 4'b1000, S1, 2'd3);
    add(4, 1'b1, 16'h1234, 4'b0001, S4, 2'd0);
    add(2, 1'b1, 16'h1234, 4'b0010, S3, 2'd1);
    add(3, 1'b0, 16'h1234, 4'b0000, 7'd0, 2'd1);
    add(2, 1'b1, 16'h1234, 4'b0010, S3, 2'd1);
    add(1, 1'b1, 16'h1234, 4'b0100, S2, 2'd2);

    reset_n = 1'b0;
    en      = 1'b1;
    bcd     = 16'h1234;
    model_reset();
    #3;
    check_out("reset_async", 4'b0000, 7'd0, 2'd0);
    @(posedge clock);
    @(negedge clock);
    check_out("reset_held", 4'b0000, 7'd0, 2'd0);
    reset_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].en, vecs[v].bcd);
      check_out($sformatf("vec%0d", v), vecs[v].an, vecs[v].seg, vecs[v].idx);
    end

    // Valid 9 and invalid nibble A.
    do_reset();
    step(1'b1, 16'h00A9);
    check_out("nine", 4'b0001, S9, 2'd0);
    steps(4, 1'b1, 16'h00A9);
    check_out("dash", 4'b0010, DASH, 2'd1);

    // Reset pulsed mid-slot of digit 2 clears outputs before the next edge.
    do_reset();
    steps(9, 1'b1, 16'h1234);
    check_out("pre_rst", 4'b0100, S2, 2'd2);
    #2 reset_n = 1'b0;
    #1 check_out("mid_rst", 4'b0000, 7'd0, 2'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 16'h1234);
    check_out("restart", 4'b0001, S4, 2'd0);
    steps(3, 1'b1, 16'h1234);
    check_out("restart_hold", 4'b0001, S4, 2'd0);
    step(1'b1, 16'h1234);
    check_out("restart_next", 4'b0010, S3, 2'd1);

`ifdef LZB_EN
    do_reset();
    step(1'b1, 16'h0007);
    check_out("lzb_d0", 4'b0001, S7, 2'd0);
    steps(4, 1'b1, 16'h0007);
    check_out("lzb_d1", 4'b0010, 7'd0, 2'd1);
    steps(4, 1'b1, 16'h0007);
    check_out("lzb_d2", 4'b0100, 7'd0, 2'd2);
    steps(4, 1'b1, 16'h0007);
    check_out("lzb_d3", 4'b1000, 7'd0, 2'd3);
    do_reset();
    step(1'b1, 16'h0000);
    check_out("lzb_zero", 4'b0001, S0, 2'd0);
    do_reset();
    steps(5, 1'b1, 16'h0102);
    check_out("lzb_inner", 4'b0010, S0, 2'd1);
`else
    do_reset();
    steps(13, 1'b1, 16'h0007);
    check_out("zero_shown", 4'b1000, S0, 2'd3);
`endif

    // Randomized run against the model.
    do_reset();
    begin
      logic        e;
      logic [15:0] b;
      b = 16'h0;
      for (int n = 0; n < 400; n++) begin
        e = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          b = 16'($urandom);
          case ($urandom_range(0, 3))
            0: b[15:4]  = '0;
            1: b[15:8]  = '0;
            2: b[15:12] = '0;
            default: ;
          endcase
        end
        step(e, b);
        check_out($sformatf("rnd%0d", n), m_an, m_seg, m_idx);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
